grid_cursor: RTL

// Parametrised, clocked successor to the 5x5 box selector: keeps a (row,col) cursor on a

---
 rtl/grid_cursor.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/grid_cursor.sv
// Grid cursor driven by four debounced direction buttons with edge-detected moves,
// hold-to-auto-repeat, wrap/saturate borders and a synchronous clamped load.
module grid_cursor #(
  parameter int ROWS          = 5,
  parameter int COLS          = 5,
  parameter int ROW_W         = 3,
  parameter int COL_W         = 3,
  parameter int WRAP          = 1,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btnL,
  input  logic             btnR,
  input  logic             btnU,
  input  logic             btnD,
  input  logic             en,
  input  logic             load,
  input  logic [ROW_W-1:0] load_row,
  input  logic [COL_W-1:0] load_col,
  output logic [ROW_W-1:0] box_row,
  output logic [COL_W-1:0] box_col,
  output logic             moved,
  output logic             bump
);

  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
  localparam logic [CNT_W-1:0] HOLD_T  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_T   = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {DIR_NONE, DIR_L, DIR_R, DIR_U, DIR_D} dir_t;
  typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

  state_t           state;
  dir_t             dir;
  dir_t             dir_q;
  logic [CNT_W-1:0] cnt;

  logic [ROW_W-1:0] step_row;
  logic [COL_W-1:0] step_col;
  logic             step_moved;
  logic             step_bump;
  logic             step_req;
  logic             active;
  logic [ROW_W-1:0] clamp_row;
  logic [COL_W-1:0] clamp_col;

  always_comb begin
    dir = DIR_NONE;
    if (btnL)      dir = DIR_L;
    else if (btnR) dir = DIR_R;
    else if (btnU) dir = DIR_U;
    else if (btnD) dir = DIR_D;
  end

  always_comb begin
    clamp_row = (load_row > ROW_MAX) ? ROW_MAX : load_row;
    clamp_col = (load_col > COL_MAX) ? COL_MAX : load_col;
  end

  // Candidate position for one step in the current direction, with border handling.
  always_comb begin
    step_row   = box_row;
    step_col   = box_col;
    step_moved = 1'b0;
    step_bump  = 1'b0;
    case (dir)
      DIR_L: begin
        if (box_col != '0) begin
          step_col   = box_col - 1'b1;
          step_moved = 1'b1;
        end else if (WRAP != 0) begin
          step_col   = COL_MAX;
          step_moved = 1'b1;
        end else begin
          step_bump  = 1'b1;
        end
      end
      DIR_R: begin
        if (box_col != COL_MAX) begin
          step_col   = box_col + 1'b1;
          step_moved = 1'b1;
        end else if (WRAP != 0) begin
          step_col   = '0;
          step_moved = 1'b1;
        end else begin
          step_bump  = 1'b1;
        end
      end
      DIR_U: begin
        if (box_row != '0) begin
          step_row   = box_row - 1'b1;
          step_moved = 1'b1;
        end else if (WRAP != 0) begin
          step_row   = ROW_MAX;
          step_moved = 1'b1;
        end else begin
          step_bump  = 1'b1;
        end
      end
      DIR_D: begin
        if (box_row != ROW_MAX) begin
          step_row   = box_row + 1'b1;
          step_moved = 1'b1;
        end else if (WRAP != 0) begin
          step_row   = '0;
          step_moved = 1'b1;
        end else begin
          step_bump  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    active   = en && (dir != DIR_NONE);
    step_req = 1'b0;
    if (active && !load) begin
      case (state)
        IDLE:    step_req = 1'b1;
        HELD:    step_req = (dir != dir_q) || (cnt == HOLD_T);
        REPEAT:  step_req = (dir != dir_q) || (cnt == REP_T);
        default: step_req = 1'b0;
      endcase
    end
  end

  // load freezes state/cnt for its cycle; steps are suppressed by step_req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dir_q   <= DIR_NONE;
      cnt     <= '0;
      box_row <= '0;
      box_col <= '0;
      moved   <= 1'b0;
      bump    <= 1'b0;
    end else begin
      moved <= 1'b0;
      bump  <= 1'b0;
      if (load) begin
        box_row <= clamp_row;
        box_col <= clamp_col;
      end else begin
        if (step_req) begin
          box_row <= step_row;
          box_col <= step_col;
          moved   <= step_moved;
          bump    <= step_bump;
        end
        case (state)
          IDLE: begin
            if (active) begin
              state <= HELD;
              dir_q <= dir;
              cnt   <= '0;
            end
          end
          HELD: begin
            if (!active) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (dir != dir_q) begin
              dir_q <= dir;
              cnt   <= '0;
            end else if (cnt == HOLD_T) begin
              state <= REPEAT;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          REPEAT: begin
            if (!active) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (dir != dir_q) begin
              state <= HELD;
              dir_q <= dir;
              cnt   <= '0;
            end else if (cnt == REP_T) begin
              cnt <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
